// File: rtl/vga_grid_pkg.sv
// Shared types for the block-grid renderer: colour schemes, colour triplet and scheme colour table.
package vga_grid_pkg;

   typedef enum logic [1:0] {
      SCH_CLASSIC  = 2'b00,
      SCH_INVERSE  = 2'b01,
      SCH_WARM     = 2'b10,
      SCH_CONTRAST = 2'b11
   } scheme_e;

   typedef enum logic [1:0] {
      PIX_OFF  = 2'b00,
      PIX_ON   = 2'b01,
      PIX_LINE = 2'b10
   } pix_kind_e;

   typedef enum logic {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_e;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb_t;

   function automatic rgb_t scheme_colour(input scheme_e sch, input pix_kind_e kind);
      rgb_t c;
      c = '0;
      case (sch)
         SCH_CLASSIC: case (kind)
            PIX_ON:   c = '{r: 3'd7, g: 3'd7, b: 2'd3};
            PIX_LINE: c = '{r: 3'd2, g: 3'd2, b: 2'd1};
            default:  c = '{r: 3'd0, g: 3'd0, b: 2'd0};
         endcase
         SCH_INVERSE: case (kind)
            PIX_ON:   c = '{r: 3'd0, g: 3'd0, b: 2'd0};
            PIX_LINE: c = '{r: 3'd4, g: 3'd4, b: 2'd2};
            default:  c = '{r: 3'd7, g: 3'd7, b: 2'd3};
         endcase
         SCH_WARM: case (kind)
            PIX_ON:   c = '{r: 3'd7, g: 3'd7, b: 2'd1};
            PIX_LINE: c = '{r: 3'd0, g: 3'd0, b: 2'd1};
            default:  c = '{r: 3'd7, g: 3'd1, b: 2'd1};
         endcase
         default: case (kind)
            PIX_ON:   c = '{r: 3'd7, g: 3'd1, b: 2'd1};
            PIX_LINE: c = '{r: 3'd0, g: 3'd0, b: 2'd1};
            default:  c = '{r: 3'd7, g: 3'd7, b: 2'd1};
         endcase
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_grid_tick_gen.sv
// Level-scaled update-tick divider: fires once every (threshold+1) tick_in pulses.
module vga_grid_tick_gen
   import vga_grid_pkg::*;
#(
   parameter int TICK_BASE = 10,
   parameter int LVL_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_in,
   input  logic [LVL_W-1:0] level,
   input  logic             restart,
   output logic             update_tick
);

   localparam int unsigned BASE = TICK_BASE;
   localparam int DW = $clog2(TICK_BASE + 1);

   logic [DW-1:0] div_q;
   int unsigned   thresh;

   always_comb begin
      thresh = 1;
      if (32'(level) + 1 < BASE) thresh = BASE - 32'(level);
   end

   // Compare against the live threshold so a level raise mid-count fires at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q       <= '0;
         update_tick <= 1'b0;
      end else begin
         update_tick <= 1'b0;
         if (restart) begin
            div_q <= '0;
         end else if (tick_in) begin
            if (32'(div_q) >= thresh) begin
               div_q       <= '0;
               update_tick <= 1'b1;
            end else begin
               div_q <= div_q + DW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/vga_grid_renderer.sv
// ROWS x COLS block-grid framebuffer with sequenced clear, cell tracking from pixel coordinates,
// two-stage colour pipeline and the update-tick generator for the stacking game.
module vga_grid_renderer
   import vga_grid_pkg::*;
#(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int CELL_W     = 80,
   parameter int CELL_H     = 60,
   parameter int GRID_LINES = 0,
   parameter int BLINK_FR   = 16,
   parameter int TICK_BASE  = 10,
   parameter int LVL_W      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pix_en,
   input  logic [9:0]              pixel_x,
   input  logic [9:0]              pixel_y,
   input  logic                    in_display,
   input  logic                    wr_en,
   input  logic [$clog2(ROWS)-1:0] wr_row,
   input  logic [COLS-1:0]         wr_data,
   input  logic                    clr,
   output logic                    busy,
   input  logic [1:0]              scheme,
   input  logic                    blink_en,
   input  logic [$clog2(ROWS)-1:0] blink_row,
   input  logic                    tick_in,
   input  logic [LVL_W-1:0]        level,
   input  logic                    restart,
   output logic                    update_tick,
   output logic [2:0]              vga_r,
   output logic [2:0]              vga_g,
   output logic [1:0]              vga_b
);

   localparam int RW  = $clog2(ROWS);
   localparam int CW  = $clog2(COLS + 1);
   localparam int RCW = $clog2(ROWS + 1);
   localparam int SXW = $clog2(CELL_W);
   localparam int SYW = $clog2(CELL_H);
   localparam int FW  = $clog2(BLINK_FR + 1);

   logic [COLS-1:0] grid [ROWS];

   clr_state_e state_q, state_d;
   logic [RW-1:0] clr_idx_q, clr_idx_d;
   logic row_zero, wr_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= CLR_IDLE;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      row_zero  = 1'b0;
      wr_ok     = 1'b0;
      if (clr) begin
         state_d   = CLR_SWEEP;
         clr_idx_d = '0;
      end else if (state_q == CLR_SWEEP) begin
         row_zero = 1'b1;
         if (clr_idx_q == RW'(ROWS - 1)) state_d = CLR_IDLE;
         else clr_idx_d = clr_idx_q + RW'(1);
      end else begin
         wr_ok = wr_en;
      end
   end

   assign busy = (state_q == CLR_SWEEP);

   // Logical row 0 is the bottom of the screen, stored in the last physical row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ROWS; i++) grid[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < ROWS; i++) begin
            if (row_zero && 32'(clr_idx_q) == i) grid[i] <= '0;
            else if (wr_ok && 32'(wr_row) == ROWS - 1 - i) grid[i] <= wr_data;
         end
      end
   end

   logic [CW-1:0]  col_q, col_d;
   logic [RCW-1:0] row_q, row_d;
   logic [SXW-1:0] subx_q, subx_d;
   logic [SYW-1:0] suby_q, suby_d;
   logic [9:0]     prev_y_q;

   // Counters hold the previous pixel; the *_d values describe the pixel now on the inputs.
   always_comb begin
      col_d  = col_q;
      subx_d = subx_q;
      row_d  = row_q;
      suby_d = suby_q;
      if (pixel_x == '0) begin
         col_d  = '0;
         subx_d = '0;
         if (pixel_y == '0) begin
            row_d  = '0;
            suby_d = '0;
         end else if (pixel_y != prev_y_q) begin
            if (suby_q == SYW'(CELL_H - 1)) begin
               suby_d = '0;
               if (row_q != RCW'(ROWS)) row_d = row_q + RCW'(1);
            end else begin
               suby_d = suby_q + SYW'(1);
            end
         end
      end else if (subx_q == SXW'(CELL_W - 1)) begin
         subx_d = '0;
         if (col_q != CW'(COLS)) col_d = col_q + CW'(1);
      end else begin
         subx_d = subx_q + SXW'(1);
      end
   end

   logic [COLS-1:0] row_bits;
   logic cell_bit, in_grid, line_hit, blink_hit, frame_start;

   always_comb begin
      row_bits = '0;
      for (int unsigned i = 0; i < ROWS; i++) if (32'(row_d) == i) row_bits = grid[i];
      cell_bit = 1'b0;
      for (int unsigned i = 0; i < COLS; i++) if (32'(col_d) == i) cell_bit = row_bits[COLS-1-i];
   end

   logic fr_phase_q;
   logic [FW-1:0] fr_cnt_q;

   assign in_grid     = (col_d != CW'(COLS)) && (row_d != RCW'(ROWS));
   assign line_hit    = (GRID_LINES != 0) && ((subx_d == '0) || (suby_d == '0));
   assign blink_hit   = blink_en && fr_phase_q && (32'(row_d) + 32'(blink_row) == ROWS - 1);
   assign frame_start = (pixel_x == '0) && (pixel_y == '0);

   logic s1_cell, s1_disp, s1_in_grid, s1_line, s1_blink;
   rgb_t colour_q, colour_d;
   pix_kind_e kind;

   always_comb begin
      kind = PIX_OFF;
      if (s1_line) kind = PIX_LINE;
      else if (s1_cell ^ s1_blink) kind = PIX_ON;
      if (!s1_in_grid) kind = PIX_OFF;
      colour_d = s1_disp ? scheme_colour(scheme_e'(scheme), kind) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q      <= '0;
         row_q      <= '0;
         subx_q     <= '0;
         suby_q     <= '0;
         prev_y_q   <= '0;
         s1_cell    <= 1'b0;
         s1_disp    <= 1'b0;
         s1_in_grid <= 1'b0;
         s1_line    <= 1'b0;
         s1_blink   <= 1'b0;
         colour_q   <= '0;
      end else if (pix_en) begin
         col_q      <= col_d;
         row_q      <= row_d;
         subx_q     <= subx_d;
         suby_q     <= suby_d;
         prev_y_q   <= pixel_y;
         s1_cell    <= cell_bit;
         s1_disp    <= in_display;
         s1_in_grid <= in_grid;
         s1_line    <= line_hit;
         s1_blink   <= blink_hit;
         colour_q   <= colour_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fr_cnt_q   <= '0;
         fr_phase_q <= 1'b0;
      end else if (!blink_en) begin
         fr_cnt_q   <= '0;
         fr_phase_q <= 1'b0;
      end else if (pix_en && frame_start) begin
         if (fr_cnt_q == FW'(BLINK_FR - 1)) begin
            fr_cnt_q   <= '0;
            fr_phase_q <= ~fr_phase_q;
         end else begin
            fr_cnt_q <= fr_cnt_q + FW'(1);
         end
      end
   end

   assign vga_r = colour_q.r;
   assign vga_g = colour_q.g;
   assign vga_b = colour_q.b;

   vga_grid_tick_gen #(
      .TICK_BASE (TICK_BASE),
      .LVL_W     (LVL_W)
   ) u_tick_gen (
      .clk         (clk),
      .reset       (reset),
      .tick_in     (tick_in),
      .level       (level),
      .restart     (restart),
      .update_tick (update_tick)
   );

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed bench for vga_grid_renderer: one plain instance and one with grid lines enabled.
module tb_vga_grid_renderer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       pix_en = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic       in_display = 1'b1;
   logic       wr_en = 1'b0;
   logic [2:0] wr_row = '0;
   logic [7:0] wr_data = '0;
   logic       clr = 1'b0;
   logic [1:0] scheme = 2'b00;
   logic       blink_en = 1'b0;
   logic [2:0] blink_row = '0;
   logic       tick_in = 1'b0;
   logic [2:0] level = '0;
   logic       restart = 1'b0;

   logic       busy0, busy1, tick0, tick1;
   logic [2:0] r0, g0, r1, g1;
   logic [1:0] b0, b1;
   logic [7:0] rgb0, rgb1;

   int checks = 0;
   int errors = 0;

   assign rgb0 = {r0, g0, b0};
   assign rgb1 = {r1, g1, b1};

   always #5 clk = ~clk;

   vga_grid_renderer #(
      .ROWS (8), .COLS (8), .CELL_W (80), .CELL_H (60),
      .GRID_LINES (0), .BLINK_FR (2), .TICK_BASE (10), .LVL_W (3)
   ) dut0 (
      .clk (clk), .reset (reset), .pix_en (pix_en), .pixel_x (pixel_x), .pixel_y (pixel_y),
      .in_display (in_display), .wr_en (wr_en), .wr_row (wr_row), .wr_data (wr_data),
      .clr (clr), .busy (busy0), .scheme (scheme), .blink_en (blink_en), .blink_row (blink_row),
      .tick_in (tick_in), .level (level), .restart (restart), .update_tick (tick0),
      .vga_r (r0), .vga_g (g0), .vga_b (b0)
   );

   vga_grid_renderer #(
      .ROWS (8), .COLS (8), .CELL_W (80), .CELL_H (60),
      .GRID_LINES (1), .BLINK_FR (2), .TICK_BASE (10), .LVL_W (3)
   ) dut1 (
      .clk (clk), .reset (reset), .pix_en (pix_en), .pixel_x (pixel_x), .pixel_y (pixel_y),
      .in_display (in_display), .wr_en (wr_en), .wr_row (wr_row), .wr_data (wr_data),
      .clr (clr), .busy (busy1), .scheme (scheme), .blink_en (blink_en), .blink_row (blink_row),
      .tick_in (tick_in), .level (level), .restart (restart), .update_tick (tick1),
      .vga_r (r1), .vga_g (g1), .vga_b (b1)
   );

   function automatic logic [7:0] rgb(input int r, input int g, input int b);
      return {3'(r), 3'(g), 2'(b)};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input int row, input logic [7:0] data);
      wr_en = 1'b1; wr_row = 3'(row); wr_data = data;
      step();
      wr_en = 1'b0;
   endtask

   // Walk the raster from (0,0) to the target so the cell counters track it, then let S2 settle.
   task automatic probe(input int tx, input int ty, input logic disp);
      pix_en = 1'b1; in_display = disp;
      for (int y = 0; y <= ty; y++) begin
         pixel_x = '0; pixel_y = 10'(y); step();
      end
      for (int x = 1; x <= tx; x++) begin
         pixel_x = 10'(x); step();
      end
      step();
      pix_en = 1'b0; in_display = 1'b1;
   endtask

   task automatic pulse_tick();
      tick_in = 1'b1; step(); tick_in = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1; step(); restart = 1'b0;
   endtask

   initial begin
      // reset state
      step(); step();
      check("rst_rgb0", rgb0, 8'h00);
      check("rst_busy0", {7'b0, busy0}, 8'h00);
      check("rst_tick0", {7'b0, tick0}, 8'h00);
      #2 reset = 1'b1;
      step();

      // bottom row, outer cells lit
      write_row(0, 8'b1000_0001);
      probe(0, 420, 1'b1);   check("row0_left_on", rgb0, rgb(7, 7, 3));
      probe(560, 420, 1'b1); check("row0_right_on", rgb0, rgb(7, 7, 3));
      probe(80, 420, 1'b1);  check("row0_mid_off", rgb0, rgb(0, 0, 0));
      probe(300, 360, 1'b1); check("row1_empty", rgb0, rgb(0, 0, 0));
      scheme = 2'b01;
      probe(700, 420, 1'b1); check("outside_grid_off", rgb0, rgb(7, 7, 3));
      scheme = 2'b10;
      probe(560, 420, 1'b1); check("warm_on", rgb0, rgb(7, 7, 1));
      scheme = 2'b00;

      // blinking logical row 2 (screen lines 300..359); each probe is one frame
      write_row(2, 8'hF0);
      blink_row = 3'd2; blink_en = 1'b1;
      probe(80, 300, 1'b1);  check("blink_f1_normal", rgb0, rgb(7, 7, 3));
      probe(80, 300, 1'b1);  check("blink_f2_swapped", rgb0, rgb(0, 0, 0));
      probe(560, 420, 1'b1); check("blink_other_row", rgb0, rgb(7, 7, 3));
      probe(80, 300, 1'b1);  check("blink_f4_normal", rgb0, rgb(7, 7, 3));
      blink_en = 1'b0;

      // grid lines
      scheme = 2'b01;
      probe(80, 100, 1'b1);  check("gl_vline", rgb1, rgb(4, 4, 2));
      check("nogl_vline", rgb0, rgb(7, 7, 3));
      probe(100, 120, 1'b1); check("gl_hline", rgb1, rgb(4, 4, 2));
      probe(100, 100, 1'b1); check("gl_cell_off", rgb1, rgb(7, 7, 3));
      probe(80, 120, 1'b0);  check("gl_blanked", rgb1, rgb(0, 0, 0));
      scheme = 2'b00;

      // update tick, level 0: every 11th tick_in
      pulse_restart();
      for (int n = 1; n <= 22; n++) begin
         pulse_tick();
         check("tick_l0", {7'b0, tick0}, {7'b0, (n % 11 == 0)});
         step();
         check("tick_l0_width", {7'b0, tick0}, 8'h00);
         step(); step();
      end
      // level 7: every 4th
      level = 3'd7;
      pulse_restart();
      for (int n = 1; n <= 8; n++) begin
         pulse_tick();
         check("tick_l7", {7'b0, tick0}, {7'b0, (n % 4 == 0)});
         step(); step(); step();
      end
      // restart mid-count
      pulse_tick(); step(); pulse_tick(); step();
      pulse_restart();
      for (int n = 1; n <= 4; n++) begin
         pulse_tick();
         check("tick_restart", {7'b0, tick0}, {7'b0, (n == 4)});
         step(); step(); step();
      end
      // restart wins over a simultaneous tick_in
      pulse_tick(); pulse_tick(); pulse_tick();
      restart = 1'b1; tick_in = 1'b1; step(); restart = 1'b0; tick_in = 1'b0;
      check("tick_restart_prio", {7'b0, tick0}, 8'h00);
      // level raised mid-count fires on the next tick_in
      level = 3'd0;
      for (int n = 0; n < 6; n++) begin pulse_tick(); step(); end
      level = 3'd7;
      pulse_tick();
      check("tick_level_jump", {7'b0, tick0}, 8'h01);
      level = 3'd0;

      // clear sweep, with a write dropped at sweep clk 3
      for (int r = 0; r < 8; r++) write_row(r, 8'hFF);
      clr = 1'b1; step(); clr = 1'b0;
      check("clr_busy_start", {7'b0, busy0}, 8'h01);
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) begin wr_en = 1'b1; wr_row = 3'd7; wr_data = 8'hFF; end
         step();
         wr_en = 1'b0;
         check("clr_busy", {7'b0, busy0}, {7'b0, (k < 8)});
      end
      probe(10, 30, 1'b1);   check("clr_top_dropped_wr", rgb0, rgb(0, 0, 0));
      probe(600, 450, 1'b1); check("clr_bottom", rgb0, rgb(0, 0, 0));
      probe(300, 200, 1'b1); check("clr_middle", rgb0, rgb(0, 0, 0));

      // clr while busy restarts the sweep
      clr = 1'b1; step(); clr = 1'b0;
      step(); step();
      clr = 1'b1; step(); clr = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k >= 7) check("clr_restart_busy", {7'b0, busy0}, {7'b0, (k < 8)});
      end

      // asynchronous reset during a sweep and mid-line
      write_row(0, 8'hFF);
      probe(0, 420, 1'b1);   check("pre_reset_on", rgb0, rgb(7, 7, 3));
      clr = 1'b1; step(); clr = 1'b0; step();
      pix_en = 1'b1; pixel_x = 10'd30; pixel_y = 10'd200; step();
      #2 reset = 1'b0;
      #1;
      check("async_rst_rgb0", rgb0, 8'h00);
      check("async_rst_rgb1", rgb1, 8'h00);
      check("async_rst_busy0", {7'b0, busy0}, 8'h00);
      check("async_rst_busy1", {7'b0, busy1}, 8'h00);
      check("async_rst_tick", {6'b0, tick0, tick1}, 8'h00);
      pix_en = 1'b0;
      step();
      reset = 1'b1;
      step();
      probe(0, 420, 1'b1);   check("post_reset_row0", rgb0, rgb(0, 0, 0));
      probe(300, 450, 1'b1); check("post_reset_row0_mid", rgb0, rgb(0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
